// File: rtl/mult_sequencer.sv
// mult_sequencer: step-index controller for the shift-add multiplier datapath
// Drives count into the control memory, with start/busy/done handshake, abort and early exit.
module mult_sequencer #(
    parameter int         WIDTH     = 4,
    parameter logic [3:0] IDLE_CODE = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       y_lsb,
    input  logic       y_zero,
    output logic [3:0] count,
    output logic [3:0] iter,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, LDX, LDY, ACC, SHF, STO, FIN} state_t;
    state_t     state, nxt;
    logic [3:0] iter_inc;
    function automatic state_t decide(input logic [3:0] it, input logic lsb, input logic zero);
        return (zero || it == 4'(WIDTH)) ? STO : lsb ? ACC : SHF;
    endfunction
    function automatic logic [3:0] code_of(input state_t s);
        return s == LDX ? 4'd0 : s == LDY ? 4'd1 : s == ACC ? 4'd2 :
               s == SHF ? 4'd3 : s == STO ? 4'd4 : IDLE_CODE;
    endfunction
    assign iter_inc = (iter >= 4'(WIDTH)) ? iter : iter + 4'd1;
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? LDX : IDLE;
            LDX:     nxt = LDY;
            LDY:     nxt = decide(iter, y_lsb, y_zero);
            ACC:     nxt = SHF;
            SHF:     nxt = decide(iter_inc, y_lsb, y_zero);
            STO:     nxt = FIN;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end
    // Outputs are registered from the next state so count tracks the state entered on each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= IDLE_CODE;
            iter  <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            count <= code_of(nxt);
            busy  <= nxt inside {LDX, LDY, ACC, SHF, STO};
            done  <= nxt == FIN;
            if (nxt == LDX) iter <= 4'd0;
            else if (state == SHF && nxt != IDLE) iter <= iter_inc;
        end
    end
endmodule
